// File: rtl/sram_responder.sv
// sram_responder
//   On-chip 16-bit word store that answers the CPU control unit's active-low
//   memory strobes in place of external SRAM. Read data is returned READ_LAT
//   cycles after the request edge; writes commit on the request edge.
//   Optional build macro MMIO_SWITCH_EN maps address 0xFFFF to the board
//   switches (read) and the hex display register (write).
// Ports
//   Clk, Reset            clock (rising edge), async active-high reset
//   Mem_CE/OE/WE/UB/LB    active-low chip enable, read, write, byte lanes
//   ADDR, Data_from_CPU   word address and write data
//   Data_to_CPU           registered read data
//   Data_valid            Data_to_CPU holds the response for the current read
//   Busy                  any state other than IDLE
//   Err                   one-cycle pulse on protocol or range fault
//   Switches, Hex_out     (MMIO_SWITCH_EN only) switch input, hex output
//
//   state   | meaning
//   IDLE    | waiting for a request
//   RD_WAIT | read latched, counting down wait cycles
//   RD_HOLD | read data valid, held while request is stable
//   WR_HOLD | write committed, waiting for WE/CE release
module sram_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
`ifdef MMIO_SWITCH_EN
  input  logic [15:0] Switches,
  output logic [15:0] Hex_out,
`endif
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic        Busy,
  output logic        Err
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [16:0] DEPTH_W = 17'(1) << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1  = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, WR_HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        wr_en;
  logic [15:0] mem [0:DEPTH-1];

  logic        addr_in_array, addr_is_mmio, addr_ok;
  logic        rd_in_array, rd_is_mmio;
  logic [15:0] rd_word, rd_masked;

`ifdef MMIO_SWITCH_EN
  logic [15:0] hex_q, hex_d;
  assign addr_is_mmio = (ADDR == 16'hFFFF);
  assign rd_is_mmio   = (rd_addr_q == 16'hFFFF);
  assign Hex_out      = hex_q;
`else
  assign addr_is_mmio = 1'b0;
  assign rd_is_mmio   = 1'b0;
`endif

  // The MMIO address takes priority over the array even if DEPTH covers it.
  assign addr_in_array = ({1'b0, ADDR} < DEPTH_W) && !addr_is_mmio;
  assign addr_ok       = addr_in_array || addr_is_mmio;
  assign rd_in_array   = ({1'b0, rd_addr_q} < DEPTH_W) && !rd_is_mmio;

  always_comb begin
    rd_word = 16'h0000;
    if (rd_in_array) rd_word = mem[rd_addr_q[DEPTH_LOG2-1:0]];
`ifdef MMIO_SWITCH_EN
    else if (rd_is_mmio) rd_word = Switches;
`endif
    rd_masked = {Mem_UB ? 8'h00 : rd_word[15:8], Mem_LB ? 8'h00 : rd_word[7:0]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    wr_en     = 1'b0;
`ifdef MMIO_SWITCH_EN
    hex_d     = hex_q;
`endif
    case (state_q)
      IDLE: begin
        if (!Mem_CE && !Mem_WE) begin
          wr_en   = 1'b1;
          state_d = WR_HOLD;
          err_d   = !Mem_OE || !addr_ok;
`ifdef MMIO_SWITCH_EN
          if (addr_is_mmio) begin
            if (!Mem_UB) hex_d[15:8] = Data_from_CPU[15:8];
            if (!Mem_LB) hex_d[7:0]  = Data_from_CPU[7:0];
          end
`endif
        end else if (!Mem_CE && !Mem_OE) begin
          rd_addr_d = ADDR;
          cnt_d     = LAT_M1;
          state_d   = RD_WAIT;
          err_d     = !addr_ok;
        end
      end
      RD_WAIT: begin
        if (Mem_CE || Mem_OE) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          data_d  = rd_masked;
          valid_d = 1'b1;
          state_d = RD_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_HOLD: begin
        if (Mem_CE || Mem_OE) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (ADDR != rd_addr_q) begin
          valid_d   = 1'b0;
          rd_addr_d = ADDR;
          cnt_d     = LAT_M1;
          state_d   = RD_WAIT;
          err_d     = !addr_ok;
        end
      end
      WR_HOLD: begin
        if (Mem_WE || Mem_CE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rd_addr_q <= 16'h0000;
      data_q    <= 16'h0000;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef MMIO_SWITCH_EN
      hex_q     <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef MMIO_SWITCH_EN
      hex_q     <= hex_d;
`endif
    end
  end

  // Array is never cleared; Reset only blocks a write sampled on its edge.
  always_ff @(posedge Clk) begin
    if (wr_en && !Reset && addr_in_array) begin
      if (!Mem_UB) mem[ADDR[DEPTH_LOG2-1:0]][15:8] <= Data_from_CPU[15:8];
      if (!Mem_LB) mem[ADDR[DEPTH_LOG2-1:0]][7:0]  <= Data_from_CPU[7:0];
    end
  end

  assign Data_to_CPU = data_q;
  assign Data_valid  = valid_q;
  assign Busy        = (state_q != IDLE);
  assign Err         = err_q;

endmodule
